shift_reg_univ: RTL

Parametrised universal shift register and successor to dff_param. Adds bidirectional shifting, parallel load and hold modes, serial outputs at both ends, and a shift counter that pulses when a full SIZE-bit word has been assembled. It serves as the serializer/deserializer primitive in the team's serial-link and test-pattern paths.

---
 rtl/shift_reg_univ_pkg.sv | 20 ++
 rtl/shift_reg_univ_cnt.sv | 39 +++
 rtl/shift_reg_univ.sv | 64 ++++++
 3 files changed

// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the counter width helper.
package shift_reg_univ_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Bits needed to count 0..size-1, never less than one.
   function automatic int calc_cw(input int size);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < size) w = i + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/shift_reg_univ_cnt.sv
// Shift counter: counts shifts modulo SIZE and pulses wrap on the edge that
// completes a word. clr restarts the count without a pulse.
module shift_reg_univ_cnt
   import shift_reg_univ_pkg::*;
#(
   parameter int SIZE = 16,
   parameter int CW   = calc_cw(SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   // Count register and registered wrap pulse; clr wins over inc.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            cnt <= '0;
         end else if (inc) begin
            if (cnt == LAST) begin
               cnt  <= '0;
               wrap <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift left, shift right and parallel load,
// serial taps at both ends, and a word-complete pulse every SIZE shifts.
module shift_reg_univ
   import shift_reg_univ_pkg::*;
#(
   parameter int              SIZE    = 16,
   parameter int              CW      = calc_cw(SIZE),
   parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
   input  logic            shift_reg_univ_port_clk,
   input  logic            shift_reg_univ_port_rst,
   input  logic            shift_reg_univ_port_en,
   input  logic [1:0]      shift_reg_univ_port_mode,
   input  logic            shift_reg_univ_port_si_lsb,
   input  logic            shift_reg_univ_port_si_msb,
   input  logic [SIZE-1:0] shift_reg_univ_port_pi,
   output logic [SIZE-1:0] shift_reg_univ_port_p,
   output logic            shift_reg_univ_port_so_msb,
   output logic            shift_reg_univ_port_so_lsb,
   output logic [CW-1:0]   shift_reg_univ_port_cnt,
   output logic            shift_reg_univ_port_word_done
);

   logic shift_en;
   logic load_en;

   assign shift_en = shift_reg_univ_port_en &
                     ((shift_reg_univ_port_mode == MODE_SHL) |
                      (shift_reg_univ_port_mode == MODE_SHR));
   assign load_en  = shift_reg_univ_port_en &
                     (shift_reg_univ_port_mode == MODE_LOAD);

   // Data register: next value selected by mode while enabled.
   always_ff @(posedge shift_reg_univ_port_clk) begin
      if (shift_reg_univ_port_rst) begin
         shift_reg_univ_port_p <= RST_VAL;
      end else if (shift_reg_univ_port_en) begin
         case (shift_reg_univ_port_mode)
            MODE_SHL:  shift_reg_univ_port_p <= {shift_reg_univ_port_p[SIZE-2:0],
                                                 shift_reg_univ_port_si_lsb};
            MODE_SHR:  shift_reg_univ_port_p <= {shift_reg_univ_port_si_msb,
                                                 shift_reg_univ_port_p[SIZE-1:1]};
            MODE_LOAD: shift_reg_univ_port_p <= shift_reg_univ_port_pi;
            default:   shift_reg_univ_port_p <= shift_reg_univ_port_p;
         endcase
      end
   end

   assign shift_reg_univ_port_so_msb = shift_reg_univ_port_p[SIZE-1];
   assign shift_reg_univ_port_so_lsb = shift_reg_univ_port_p[0];

   shift_reg_univ_cnt #(
      .SIZE (SIZE),
      .CW   (CW)
   ) u_cnt (
      .clk  (shift_reg_univ_port_clk),
      .rst  (shift_reg_univ_port_rst),
      .inc  (shift_en),
      .clr  (load_en),
      .cnt  (shift_reg_univ_port_cnt),
      .wrap (shift_reg_univ_port_word_done)
   );

endmodule
